// File: rtl/pipe_shifter.sv
// Fully pipelined barrel shifter: one 2^i shift stage per shift-amount bit, LSB first,
// each registered, sharing a single global stall so results leave in acceptance order.
module pipe_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    logic en;

    // A bubble at the output never blocks the pipe; only an unaccepted result does.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;

            logic                src_valid;
            logic [WIDTH-1:0]    src_data;
            logic [1:0]          src_mode;
            logic [SHAMT_W-1:gi] src_shamt;
            logic [TAG_W-1:0]    src_tag;
            logic [WIDTH-1:0]    data_next;

            logic                valid_reg;
            logic [WIDTH-1:0]    data_reg;
            logic [TAG_W-1:0]    tag_reg;

            if (gi == 0) begin : g_src
                assign src_valid = in_valid;
                assign src_data  = in_data;
                assign src_mode  = ctrl_mode;
                assign src_shamt = ctrl_shiftamt;
                assign src_tag   = in_tag;
            end else begin : g_src
                assign src_valid = g_stage[gi-1].valid_reg;
                assign src_data  = g_stage[gi-1].data_reg;
                assign src_mode  = g_stage[gi-1].g_fwd.mode_reg;
                assign src_shamt = g_stage[gi-1].g_fwd.shamt_reg;
                assign src_tag   = g_stage[gi-1].tag_reg;
            end

            // SRA replicates bit WIDTH-1 of this stage's input, which is still the original sign.
            always_comb begin
                data_next = src_data;
                if (src_shamt[gi]) begin
                    case (src_mode)
                        MODE_SLL: data_next = src_data << STEP;
                        MODE_SRL: data_next = src_data >> STEP;
                        MODE_SRA: data_next = WIDTH'($signed(src_data) >>> STEP);
                        MODE_ROL: data_next = (src_data << STEP) | (src_data >> (WIDTH - STEP));
                        default:  data_next = src_data;
                    endcase
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    tag_reg   <= '0;
                end else if (en) begin
                    valid_reg <= src_valid;
                    data_reg  <= data_next;
                    tag_reg   <= src_tag;
                end
            end

            // Mode and the not-yet-consumed shift bits only travel as far as a later stage needs them.
            if (gi < SHAMT_W - 1) begin : g_fwd
                logic [1:0]            mode_reg;
                logic [SHAMT_W-1:gi+1] shamt_reg;

                always_ff @(posedge clock) begin
                    if (!reset) begin
                        mode_reg  <= '0;
                        shamt_reg <= '0;
                    end else if (en) begin
                        mode_reg  <= src_mode;
                        shamt_reg <= src_shamt[SHAMT_W-1:gi+1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[SHAMT_W-1].valid_reg;
    assign out_data  = g_stage[SHAMT_W-1].data_reg;
    assign out_tag   = g_stage[SHAMT_W-1].tag_reg;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: a 32-bit instance for directed, streaming, stall and
// reset scenarios, and an 8-bit instance for randomized traffic against a whole-shift model.
module tb_pipe_shifter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_shamt;
    logic [1:0]  a_mode;
    logic [4:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_shamt;
    logic [1:0]  b_mode;
    logic [4:0]  b_in_tag, b_out_tag;

    int checks = 0;
    int passed = 0;

    pipe_shifter #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .ctrl_shiftamt(a_shamt), .ctrl_mode(a_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_tag(a_out_tag)
    );

    pipe_shifter #(.WIDTH(8), .SHAMT_W(3), .TAG_W(5)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .ctrl_shiftamt(b_shamt), .ctrl_mode(b_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_tag(b_out_tag)
    );

    // Whole-amount reference shifts; rotate is taken from the doubled word.
    function automatic logic [31:0] model32(input logic [31:0] d, input int amt, input logic [1:0] m);
        logic [63:0] dbl;
        case (m)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return 32'($signed(d) >>> amt);
            default: begin
                dbl = {d, d} << amt;
                return dbl[63:32];
            end
        endcase
    endfunction

    function automatic logic [7:0] model8(input logic [7:0] d, input int amt, input logic [1:0] m);
        logic [15:0] dbl;
        case (m)
            2'b00:   return d << amt;
            2'b01:   return d >> amt;
            2'b10:   return 8'($signed(d) >>> amt);
            default: begin
                dbl = {d, d} << amt;
                return dbl[15:8];
            end
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_valid: got %b, expected 0", a_out_valid); else passed++;
        checks++; if (a_out_data !== 32'h0) $display("FAIL reset_a_data: got %h, expected 00000000", a_out_data); else passed++;
        checks++; if (a_out_tag !== 5'h0) $display("FAIL reset_a_tag: got %h, expected 00", a_out_tag); else passed++;
        checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid: got %b, expected 0", b_out_valid); else passed++;
        checks++; if (b_out_data !== 8'h0) $display("FAIL reset_b_data: got %h, expected 00", b_out_data); else passed++;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_a_in_ready: got %b, expected 1", a_in_ready); else passed++;
        checks++; if (b_in_ready !== 1'b1) $display("FAIL reset_b_in_ready: got %b, expected 1", b_in_ready); else passed++;
        $display("reset: outputs cleared, in_ready high");
    endtask

    // One isolated operation on the 32-bit instance, checking result, tag and latency.
    task automatic op32(input string name, input logic [31:0] d, input logic [4:0] amt,
                        input logic [1:0] m, input logic [4:0] tag, input logic [31:0] exp);
        int n;
        @(negedge clock);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = d;
        a_shamt     = amt;
        a_mode      = m;
        a_in_tag    = tag;
        #1;
        checks++; if (a_in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b, expected 1", name, a_in_ready); else passed++;
        @(negedge clock);
        a_in_valid = 1'b0;
        n = 1;
        while (a_out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n != 5) $display("FAIL %s_latency: got %0d cycles, expected 5", name, n); else passed++;
        checks++; if (a_out_data !== exp) $display("FAIL %s_data: got %h, expected %h", name, a_out_data, exp); else passed++;
        checks++; if (a_out_tag !== tag) $display("FAIL %s_tag: got %h, expected %h", name, a_out_tag, tag); else passed++;
        $display("op %s: %h mode %0d by %0d -> %h (tag %0d, %0d cycles)", name, d, m, amt, a_out_data, a_out_tag, n);
    endtask

    task automatic test_directed();
        op32("sll_1_31",   32'h0000_0001, 5'd31, 2'b00, 5'd1, 32'h8000_0000);
        op32("sll_ff_0",   32'hFFFF_FFFF, 5'd0,  2'b00, 5'd2, 32'hFFFF_FFFF);
        op32("sra_neg_4",  32'h8000_0000, 5'd4,  2'b10, 5'd3, 32'hF800_0000);
        op32("srl_neg_4",  32'h8000_0000, 5'd4,  2'b01, 5'd4, 32'h0800_0000);
        op32("sra_pos_31", 32'h7FFF_FFFF, 5'd31, 2'b10, 5'd5, 32'h0000_0000);
        op32("rol_1",      32'h8000_0001, 5'd1,  2'b11, 5'd6, 32'h0000_0003);
        op32("rol_16",     32'h1234_5678, 5'd16, 2'b11, 5'd7, 32'h5678_1234);
        op32("rol_0",      32'hCAFE_F00D, 5'd0,  2'b11, 5'd8, 32'hCAFE_F00D);
    endtask

    // Eight back-to-back ops; optional 3-cycle out_ready drop starting at cycle stall_at.
    task automatic stream32(input string name, input int stall_at);
        logic [31:0] ops_d [8];
        logic [4:0]  ops_a [8];
        logic [1:0]  ops_m [8];
        logic [31:0] exp_q [$];
        logic [4:0]  tag_q [$];
        logic [31:0] held_d, exp_d;
        logic [4:0]  held_t, exp_t;
        logic        held;
        int sent, got, first_cyc, last_cyc, stalled;
        sent = 0; got = 0; first_cyc = -1; last_cyc = -1; stalled = 0; held = 1'b0;
        held_d = '0; held_t = '0;
        for (int i = 0; i < 8; i++) begin
            ops_d[i] = $urandom;
            ops_a[i] = 5'($urandom_range(0, 31));
            ops_m[i] = 2'($urandom_range(0, 3));
        end
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clock);
            a_out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            if (sent < 8) begin
                a_in_valid = 1'b1;
                a_in_data  = ops_d[sent];
                a_shamt    = ops_a[sent];
                a_mode     = ops_m[sent];
                a_in_tag   = 5'(sent);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (held) begin
                checks++; if (a_out_data !== held_d) $display("FAIL %s_hold_data: got %h, expected %h", name, a_out_data, held_d); else passed++;
                checks++; if (a_out_tag !== held_t) $display("FAIL %s_hold_tag: got %h, expected %h", name, a_out_tag, held_t); else passed++;
            end
            held = 1'b0;
            if (a_out_valid && !a_out_ready) begin
                stalled++;
                checks++; if (a_in_ready !== 1'b0) $display("FAIL %s_stall_in_ready: got %b, expected 0", name, a_in_ready); else passed++;
                held = 1'b1;
                held_d = a_out_data;
                held_t = a_out_tag;
            end
            if (a_in_valid && a_in_ready) begin
                exp_q.push_back(model32(ops_d[sent], int'(ops_a[sent]), ops_m[sent]));
                tag_q.push_back(5'(sent));
                sent++;
            end
            if (a_out_valid && a_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL %s_extra: got result tag %0d, expected none", name, a_out_tag);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_t = tag_q.pop_front();
                    checks++; if (a_out_data !== exp_d) $display("FAIL %s_data: got %h, expected %h", name, a_out_data, exp_d); else passed++;
                    checks++; if (a_out_tag !== exp_t) $display("FAIL %s_tag: got %0d, expected %0d", name, a_out_tag, exp_t); else passed++;
                end
                $display("%s result: tag %0d data %h at cycle %0d", name, a_out_tag, a_out_data, cyc);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
        end
        @(negedge clock);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        checks++; if (got != 8) $display("FAIL %s_count: got %0d results, expected 8", name, got); else passed++;
        if (stall_at < 0) begin
            checks++; if (last_cyc - first_cyc != 7) $display("FAIL %s_span: got %0d cycles, expected 7", name, last_cyc - first_cyc); else passed++;
        end else begin
            checks++; if (stalled != 3) $display("FAIL %s_stalled: got %0d cycles, expected 3", name, stalled); else passed++;
        end
        repeat (8) @(negedge clock);
        checks++; if (a_out_valid !== 1'b0) $display("FAIL %s_drain: got out_valid %b, expected 0", name, a_out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        stream32("b2b", -1);
    endtask

    task automatic test_stall();
        stream32("stall", 7);
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a_out_ready = 1'b1;
            a_in_valid  = 1'b1;
            a_in_data   = 32'h0000_0001;
            a_shamt     = 5'(i + 3);
            a_mode      = 2'b00;
            a_in_tag    = 5'(20 + i);
        end
        @(negedge clock);
        reset    = 1'b0;
        a_in_tag = 5'd30;
        @(negedge clock);
        reset      = 1'b1;
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) $display("FAIL midreset_valid: got %b, expected 0", a_out_valid); else passed++;
        repeat (12) begin
            @(negedge clock);
            if (a_out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) $display("FAIL midreset_ghost: got %0d valid cycles, expected 0", seen); else passed++;
        $display("midreset: 4 in-flight ops discarded");
        op32("post_reset", 32'h0000_00F0, 5'd4, 2'b01, 5'd9, 32'h0000_000F);
    endtask

    task automatic test_latency8();
        int n;
        @(negedge clock);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h80;
        b_shamt     = 3'd3;
        b_mode      = 2'b10;
        b_in_tag    = 5'd11;
        @(negedge clock);
        b_in_valid = 1'b0;
        n = 1;
        while (b_out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++; if (n != 3) $display("FAIL w8_latency: got %0d cycles, expected 3", n); else passed++;
        checks++; if (b_out_data !== 8'hF0) $display("FAIL w8_sra: got %h, expected f0", b_out_data); else passed++;
        $display("w8 op: 80 sra 3 -> %h (%0d cycles)", b_out_data, n);
    endtask

    // Random ops with random valid gaps and random backpressure on the 8-bit instance.
    task automatic test_random8();
        logic [7:0] exp_q [$];
        logic [4:0] tag_q [$];
        logic [7:0] cur_d, exp_d;
        logic [2:0] cur_a;
        logic [1:0] cur_m;
        logic [4:0] exp_t;
        int sent, got;
        sent = 0; got = 0;
        cur_d = 8'($urandom); cur_a = 3'($urandom_range(0, 7)); cur_m = 2'($urandom_range(0, 3));
        for (int cyc = 0; cyc < 600 && got < 60; cyc++) begin
            @(negedge clock);
            b_out_ready = ($urandom_range(0, 9) < 7);
            b_in_valid  = (sent < 60) && ($urandom_range(0, 3) != 0);
            b_in_data   = cur_d;
            b_shamt     = cur_a;
            b_mode      = cur_m;
            b_in_tag    = 5'(sent % 32);
            #1;
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(model8(cur_d, int'(cur_a), cur_m));
                tag_q.push_back(5'(sent % 32));
                sent++;
                cur_d = 8'($urandom); cur_a = 3'($urandom_range(0, 7)); cur_m = 2'($urandom_range(0, 3));
            end
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rand8_extra: got result tag %0d, expected none", b_out_tag);
                end else begin
                    exp_d = exp_q.pop_front();
                    exp_t = tag_q.pop_front();
                    checks++; if (b_out_data !== exp_d) $display("FAIL rand8_data: got %h, expected %h (tag %0d)", b_out_data, exp_d, exp_t); else passed++;
                    checks++; if (b_out_tag !== exp_t) $display("FAIL rand8_tag: got %0d, expected %0d", b_out_tag, exp_t); else passed++;
                end
                $display("rand8 result: tag %0d data %h", b_out_tag, b_out_data);
                got++;
            end
        end
        @(negedge clock);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        checks++; if (got != 60) $display("FAIL rand8_count: got %0d results, expected 60", got); else passed++;
    endtask

    initial begin
        reset = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0; a_shamt = '0; a_mode = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0; b_shamt = '0; b_mode = '0; b_in_tag = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_latency8();
        test_random8();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, fully pipelined barrel shifter for the processor datapath, the successor to the single-cycle 32-bit left shifter. It supports logical left, logical right, arithmetic right and rotate-left modes at any power-of-two width. One mux stage per shift-amount bit, each followed by a register, gives full throughput with a fixed latency. A valid/ready handshake on both sides with global stall lets it sit between the decode/issue logic and writeback under backpressure.

## Interface
- WIDTH, 32: data width; power of two, ≥ 2.
- SHAMT_W, $clog2(WIDTH): shift-amount width and pipeline depth (number of stages).
- TAG_W, 5: width of the opaque tag carried alongside each operation (e.g. destination register).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_data  in  WIDTH  operand.
- ctrl_shiftamt  in  SHAMT_W  shift amount, unsigned.
- ctrl_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Transfer occurs on the input side when in_valid && in_ready is high at a rising edge. Transfer occurs on the output side when out_valid && out_ready is high at a rising edge.
- Stage i (i = 0 … SHAMT_W-1), LSB first: if shamt bit i is set, shift by 2^i per mode; otherwise pass the value through.
- Fill rules per mode:
  - SLL: zero fill at the LSBs.
  - SRL: zero fill at the MSBs.
  - SRA: the MSBs are filled with bit WIDTH-1 of the stage input. This equals the original sign, because earlier stages preserve it.
  - ROL: bits shifted out at the MSB re-enter at the LSB.
- Each stage register holds: valid, data, mode, remaining shamt bits (i+1 … SHAMT_W-1), and tag.
- Global stall: en = !out_valid || out_ready.
  - When en = 1, all stage registers advance together.
  - When en = 0, all stage registers hold.
  - in_ready = en. The path from out_ready to in_ready is combinational.
- Bubbles (valid = 0) advance like data and are not collapsed. A bubble in the last stage does not cause a stall.
- Ordering is strictly preserved; results leave in acceptance order.
- shamt = 0 in any mode: out_data = in_data.
- No illegal encodings exist. All four ctrl_mode values are defined.

## Timing
- Reset (reset = 0 at an edge):
  - All valid bits, data, mode, shamt and tag registers clear to 0.
  - Outputs go to out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 from the cycle after reset.
- Reset mid-operation: all in-flight operations are discarded, with no partial output. An input offered in the same cycle as reset is not accepted.
- Latency: an operation accepted at edge k is presented with out_valid = 1 in the cycle following edge k+SHAMT_W-1. That is SHAMT_W cycles: 5 for WIDTH = 32.
- Throughput: one operation per cycle while out_ready = 1. Acceptance and output can occur in the same cycle.
- Stall behaviour:
  - out_valid && !out_ready drops in_ready in the same cycle.
  - out_data and out_tag stay stable until accepted.
  - No operation is lost or duplicated.
- out_valid, out_data and out_tag are registered outputs; there is no combinational path from the inputs to them.

## Test plan
- WIDTH = 32, SLL of 0x0000_0001 by 31 → out_data 0x8000_0000, exactly 5 cycles after acceptance; SLL of 0xFFFF_FFFF by 0 → 0xFFFF_FFFF.
- 0x8000_0000 by 4: SRA → 0xF800_0000, SRL → 0x0800_0000. 0x7FFF_FFFF SRA by 31 → 0x0000_0000.
- ROL of 0x8000_0001 by 1 → 0x0000_0003; ROL of 0x1234_5678 by 16 → 0x5678_1234.
- Stream 8 back-to-back ops with tags 0–7 and out_ready = 1: results arrive on 8 consecutive cycles in tag order. Repeat with out_ready low for 3 cycles mid-stream: in_ready is low during those cycles, outputs are held, and all 8 results still arrive with no loss, no duplication and tags in order.
- Assert reset for 1 cycle with 4 ops in flight → out_valid = 0 from the next cycle and none of the 4 results ever appear. A new op then gives its correct result after 5 cycles.
- WIDTH = 8 (SHAMT_W = 3): random mode/amount/data against a behavioural model; latency is 3 cycles.
